mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_defs.sv | 39 +++
 rtl/arb_rr2.sv | 25 ++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Package     : cpu_defs
// Description : Shared widths, FSM/owner encodings and command record for the
//               memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef struct packed {
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Fetches are always plain reads: no strobes, no write data.
    function automatic mem_cmd_t inst_cmd(input logic [ADDR_W-1:0] addr);
        mem_cmd_t c;
        c.wr    = 1'b0;
        c.wstrb = '0;
        c.addr  = addr;
        c.wdata = '0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Two-way round-robin selector; the requester not served last
//               wins a tie. Bit 0 = inst, bit 1 = data.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-outstanding memory port between the fetch
//               and memory stages using an IDLE/REQ/WAIT sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;
    mem_cmd_t   cmd_q,   cmd_d;

    logic [1:0] w_grant;
    logic       w_accept;
    logic       w_resp;
    mem_cmd_t   w_data_cmd;

    arb_rr2 u_arb (
        .req   ({data_req, inst_req}),
        .last  (last_q),
        .grant (w_grant)
    );

    always_comb begin
        w_data_cmd.wr    = data_wr;
        w_data_cmd.wstrb = data_wstrb;
        w_data_cmd.addr  = data_addr;
        w_data_cmd.wdata = data_wdata;
    end

    assign w_accept = (state_q == ST_IDLE) && (w_grant != 2'b00);
    assign w_resp   = (state_q == ST_WAIT) && mem_data_ok;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_REQ;
                    owner_d = w_grant[1] ? OWNER_DATA : OWNER_INST;
                    last_d  = w_grant[1] ? OWNER_DATA : OWNER_INST;
                    cmd_d   = w_grant[1] ? w_data_cmd : inst_cmd(inst_addr);
                end
            end
            ST_REQ: begin
                if (mem_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // last_q resets to INST so that data wins the first contested grant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_DATA;
            last_q  <= OWNER_INST;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
        end
    end

    // addr_ok is combinational from the requests, so it must be masked in reset.
    assign inst_addr_ok = resetn && w_accept && w_grant[0];
    assign data_addr_ok = resetn && w_accept && w_grant[1];

    assign mem_req   = (state_q == ST_REQ);
    assign mem_wr    = mem_req && cmd_q.wr;
    assign mem_wstrb = mem_req ? cmd_q.wstrb : '0;
    assign mem_addr  = mem_req ? cmd_q.addr  : '0;
    assign mem_wdata = mem_req ? cmd_q.wdata : '0;

    assign inst_data_ok = w_resp && (owner_q == OWNER_INST);
    assign data_data_ok = w_resp && (owner_q == OWNER_DATA);
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

endmodule
`default_nettype wire
